// File: rtl/multiexp_fp2_feeder_if.sv
// if_axi_stream: AXI-stream style packet bus between the G2 point feeder and the multiexp sink.
// Carries one data word per beat plus packet framing (sop/eop) and sideband err/mod/ctl fields.
interface if_axi_stream #(
    parameter int DAT_BITS = 381,
    parameter int MOD_BITS = 6,
    parameter int CTL_BITS = 8
);
    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;

    modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
    modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);
    modport master (output dat, val, sop, eop, err, mod, ctl, input rdy);
    modport slave  (input dat, val, sop, eop, err, mod, ctl, output rdy);
endinterface

// File: rtl/multiexp_fp2_feeder.sv
// multiexp_fp2_feeder: replays the host-loaded G2 point/scalar RAM as a packet stream,
// once per key bit, into the multiexp sink. RAM read latency is absorbed by a skid FIFO
// whose occupancy plus reads in flight never exceeds its depth (credit rule).
// Optional feature macro: MULTIEXP_FEEDER_STATS_EN adds the o_stall_cnt backpressure counter.
module multiexp_fp2_feeder #(
    parameter int DAT_BITS      = 381,
    parameter int BEATS_PER_PNT = 5,
    parameter int NUM_PASSES    = DAT_BITS,
    parameter int ADDR_BITS     = 20,
    parameter int RD_LAT        = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [63:0]          i_num_in,
    input  logic [ADDR_BITS-1:0] i_base_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_rd_en,
    output logic [ADDR_BITS-1:0] o_rd_addr,
    input  logic [DAT_BITS-1:0]  i_rd_dat,
`ifdef MULTIEXP_FEEDER_STATS_EN
    output logic [31:0]          o_stall_cnt,
`endif
    if_axi_stream.source         o_pnt_scl_if
);
    localparam int BEAT_W = $clog2(BEATS_PER_PNT + 1);
    localparam int PASS_W = $clog2(NUM_PASSES + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          numIn_q, numIn_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [63:0]          pnt_q, pnt_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     credit_q, credit_d;

    logic [RD_LAT-1:0]    retVld_q;
    logic [RD_LAT-1:0]    retSop_q;
    logic [RD_LAT-1:0]    retEop_q;

    logic [DAT_BITS-1:0]  fifoMem_q [FIFO_DEPTH];
    logic                 fifoSop_q [FIFO_DEPTH];
    logic                 fifoEop_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]     count_q;

    logic issue;
    logic lastBeat, lastPnt, lastPass, creditOk;
    logic fifoWr, fifoRd, fifoVal, fifoHeadEop;

    assign lastBeat    = (beat_q == BEAT_W'(BEATS_PER_PNT - 1));
    assign lastPnt     = (pnt_q == (numIn_q - 64'd1));
    assign lastPass    = (pass_q == PASS_W'(NUM_PASSES - 1));
    assign creditOk    = (credit_q < CNT_W'(FIFO_DEPTH));
    assign fifoVal     = (count_q != '0);
    assign fifoRd      = fifoVal && o_pnt_scl_if.rdy;
    assign fifoWr      = retVld_q[RD_LAT-1];
    assign fifoHeadEop = fifoEop_q[rdPtr_q];

    // Sequencer: walks beat/point/pass counters, issues reads under credit, detects completion
    always_comb begin
        state_d = state_q;
        numIn_d = numIn_q;
        base_d  = base_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        pnt_d   = pnt_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    numIn_d = i_num_in;
                    base_d  = i_base_addr;
                    addr_d  = i_base_addr;
                    beat_d  = '0;
                    pnt_d   = '0;
                    pass_d  = '0;
                    if (i_num_in == 64'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (creditOk) begin
                    issue = 1'b1;
                    if (lastBeat) begin
                        beat_d = '0;
                        if (lastPnt) begin
                            pnt_d  = '0;
                            addr_d = base_q;
                            if (lastPass) begin
                                state_d = DRAIN;
                            end else begin
                                pass_d = pass_q + PASS_W'(1);
                            end
                        end else begin
                            pnt_d  = pnt_q + 64'd1;
                            addr_d = addr_q + ADDR_BITS'(1);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifoRd && fifoHeadEop && (credit_q == CNT_W'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit = FIFO occupancy + reads in flight; rises on issue, falls on output handshake
    always_comb begin
        credit_d = credit_q;
        case ({issue, fifoRd})
            2'b10:   credit_d = credit_q + CNT_W'(1);
            2'b01:   credit_d = credit_q - CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    // Sequencer and credit state registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            numIn_q  <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            pnt_q    <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            numIn_q  <= numIn_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            pnt_q    <= pnt_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            credit_q <= credit_d;
        end
    end

    // Return tracker: marks which cycles carry RAM data and the framing for that beat
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            retVld_q <= '0;
            retSop_q <= '0;
            retEop_q <= '0;
        end else begin
            retVld_q[0] <= issue;
            retSop_q[0] <= issue && (beat_q == '0);
            retEop_q[0] <= issue && lastBeat;
            for (int i = 1; i < RD_LAT; i++) begin
                retVld_q[i] <= retVld_q[i-1];
                retSop_q[i] <= retSop_q[i-1];
                retEop_q[i] <= retEop_q[i-1];
            end
        end
    end

    // Skid FIFO pointers and occupancy; a write and read together leave occupancy unchanged
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (fifoWr) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (fifoRd) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({fifoWr, fifoRd})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Skid FIFO storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge i_clk) begin
        if (fifoWr) begin
            fifoMem_q[wrPtr_q] <= i_rd_dat;
            fifoSop_q[wrPtr_q] <= retSop_q[RD_LAT-1];
            fifoEop_q[wrPtr_q] <= retEop_q[RD_LAT-1];
        end
    end

    // The credit rule guarantees a free slot for every returning read
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(fifoWr && !fifoRd && (count_q == CNT_W'(FIFO_DEPTH))));
        end
    end

`ifdef MULTIEXP_FEEDER_STATS_EN
    logic [31:0] stallCnt_q;

    // Saturating count of stalled output cycles during a run
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stallCnt_q <= '0;
        end else if ((state_q == IDLE) && i_start) begin
            stallCnt_q <= '0;
        end else if ((state_q != IDLE) && fifoVal && !o_pnt_scl_if.rdy && (stallCnt_q != '1)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stallCnt_q;
`endif

    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_rd_en   = issue;
    assign o_rd_addr = addr_q;

    assign o_pnt_scl_if.val = fifoVal;
    assign o_pnt_scl_if.dat = fifoVal ? fifoMem_q[rdPtr_q] : '0;
    assign o_pnt_scl_if.sop = fifoVal && fifoSop_q[rdPtr_q];
    assign o_pnt_scl_if.eop = fifoVal && fifoEop_q[rdPtr_q];
    assign o_pnt_scl_if.err = 1'b0;
    assign o_pnt_scl_if.mod = '0;
    assign o_pnt_scl_if.ctl = '0;

endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// tb_multiexp_fp2_feeder: scoreboard bench for the G2 point feeder.
// A small RAM model returns a recognisable word per address; directed runs push the
// expected beat stream into a queue and a negedge monitor pops and compares every handshake.
module tb_multiexp_fp2_feeder;
    localparam int DW      = 16;
    localparam int BPP     = 5;
    localparam int NP      = 2;
    localparam int AW      = 4;
    localparam int RL      = 3;
    localparam int FD      = 8;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic [63:0]   numIn;
    logic [AW-1:0] baseAddr;
    logic          busy;
    logic          done;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdDat;
`ifdef MULTIEXP_FEEDER_STATS_EN
    logic [31:0]   stallCnt;
`endif

    logic          randRdy = 1'b0;
    int            cyc = 0;
    int            passCount = 0;
    int            checkCount = 0;

    beat_t         expQ[$];
    int            hsCount = 0;
    int            doneCount = 0;
    int            valCount = 0;
    int            rdCount = 0;
    int            stallCount = 0;
    int            hsCyc[$];
    int            rdCyc[$];
    logic [AW-1:0] rdLog[$];
    int            valCyc[$];
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevDat = '0;

    if_axi_stream #(.DAT_BITS(DW)) axis ();

    multiexp_fp2_feeder #(
        .DAT_BITS(DW),
        .BEATS_PER_PNT(BPP),
        .NUM_PASSES(NP),
        .ADDR_BITS(AW),
        .RD_LAT(RL),
        .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rstN),
        .i_start(start),
        .i_num_in(numIn),
        .i_base_addr(baseAddr),
        .o_busy(busy),
        .o_done(done),
        .o_rd_en(rdEn),
        .o_rd_addr(rdAddr),
        .i_rd_dat(rdDat),
`ifdef MULTIEXP_FEEDER_STATS_EN
        .o_stall_cnt(stallCnt),
`endif
        .o_pnt_scl_if(axis)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp monitor events
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ramWord(input logic [AW-1:0] a);
        return {4'hC, a, 4'h3, ~a};
    endfunction

    // RAM model with a fixed read latency of RL cycles
    logic [DW-1:0] ramPipe [RL];
    always @(posedge clk) begin
        ramPipe[0] <= rdEn ? ramWord(rdAddr) : '0;
        for (int i = 1; i < RL; i++) begin
            ramPipe[i] <= ramPipe[i-1];
        end
    end
    assign rdDat = ramPipe[RL-1];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},  64'(busy),     64'd0);
        checkOutput({tag, "_done"},  64'(done),     64'd0);
        checkOutput({tag, "_rd_en"}, 64'(rdEn),     64'd0);
        checkOutput({tag, "_addr"},  64'(rdAddr),   64'd0);
        checkOutput({tag, "_val"},   64'(axis.val), 64'd0);
        checkOutput({tag, "_sop"},   64'(axis.sop), 64'd0);
        checkOutput({tag, "_eop"},   64'(axis.eop), 64'd0);
        checkOutput({tag, "_dat"},   64'(axis.dat), 64'd0);
    endtask

    // Pulse start for one cycle and, if asked, queue the full expected beat stream
    task automatic applyStimulus(input logic [63:0] num, input logic [AW-1:0] base, input bit pushExp,
                                 output int startCyc, output logic doneAtStart);
        logic [AW-1:0] a;
        beat_t         b;
        @(posedge clk);
        #1;
        start    = 1'b1;
        numIn    = num;
        baseAddr = base;
        startCyc = cyc;
        if (pushExp) begin
            for (int ps = 0; ps < NP; ps++) begin
                for (int p = 0; p < int'(num); p++) begin
                    for (int bt = 0; bt < BPP; bt++) begin
                        a     = base + AW'(p * BPP + bt);
                        b.dat = ramWord(a);
                        b.sop = (bt == 0);
                        b.eop = (bt == BPP - 1);
                        expQ.push_back(b);
                    end
                end
            end
        end
        @(negedge clk);
        doneAtStart = done;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int doneBase);
        int n;
        n = 0;
        while ((doneCount <= doneBase) && (n < TIMEOUT)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_done_seen"}, 64'(doneCount > doneBase), 64'd1);
    endtask

    // Backpressure driver: rdy low about 30% of cycles when randomised
    initial begin
        axis.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis.rdy = randRdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on every handshake and checks hold-while-stalled behaviour
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (!rstN) begin
            prevStall = 1'b0;
        end else begin
            if (done) doneCount++;
            if (rdEn) begin
                rdCount++;
                rdCyc.push_back(cyc);
                rdLog.push_back(rdAddr);
            end
            if (axis.val) begin
                valCount++;
                valCyc.push_back(cyc);
            end
            if (prevStall) begin
                checkOutput("val_held", 64'(axis.val), 64'd1);
                checkOutput("dat_held", 64'(axis.dat), 64'(prevDat));
            end
            if (axis.val && axis.rdy) begin
                hsCount++;
                hsCyc.push_back(cyc);
                checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
                checkOutput("sideband_zero", 64'({axis.err, axis.mod, axis.ctl}), 64'd0);
                if (expQ.size() != 0) begin
                    want    = expQ.pop_front();
                    got.dat = axis.dat;
                    got.sop = axis.sop;
                    got.eop = axis.eop;
                    checkOutput("beat", 64'(got), 64'(want));
                end
            end
            if (axis.val && !axis.rdy) stallCount++;
            prevStall = axis.val && !axis.rdy;
            prevDat   = axis.dat;
        end
    end

    // Directed test sequence
    initial begin
        int   hsBase;
        int   doneBase;
        int   rdBase;
        int   valBase;
        int   stallBase;
        int   sc;
        int   n;
        logic dAtS;
        int   wrapExp [5];
        wrapExp = '{14, 15, 0, 1, 2};

        rstN     = 1'b0;
        start    = 1'b0;
        numIn    = '0;
        baseAddr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("por");
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Basic order: 3 points, 2 passes, rdy always high
        $display("[TB] basic order");
        hsBase = hsCount; doneBase = doneCount; rdBase = rdCount; valBase = valCount;
        applyStimulus(64'd3, 4'd0, 1'b1, sc, dAtS);
        waitDone("basic", doneBase);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("basic_beats", 64'(hsCount - hsBase), 64'd30);
        checkOutput("basic_done_pulses", 64'(doneCount - doneBase), 64'd1);
        checkOutput("basic_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("basic_first_read", 64'((rdCyc.size() > rdBase) ? rdCyc[rdBase] - sc : -1), 64'd1);
        checkOutput("basic_read_to_val",
                    64'(((valCyc.size() > valBase) && (rdCyc.size() > rdBase)) ? valCyc[valBase] - rdCyc[rdBase] : -1),
                    64'(RL + 1));
        checkOutput("basic_no_bubbles",
                    64'((hsCyc.size() >= hsBase + 30) ? hsCyc[hsBase + 29] - hsCyc[hsBase] : -1), 64'd29);
        checkOutput("basic_busy_low", 64'(busy), 64'd0);

        // Zero points: no reads, no output, done one cycle after start
        $display("[TB] zero points");
        rdBase = rdCount; valBase = valCount;
        applyStimulus(64'd0, 4'd5, 1'b1, sc, dAtS);
        checkOutput("zero_done_not_early", 64'(dAtS), 64'd0);
        @(negedge clk);
        checkOutput("zero_done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        checkOutput("zero_done_clear", 64'(done), 64'd0);
        repeat (10) @(negedge clk);
        #1;
        checkOutput("zero_no_reads", 64'(rdCount - rdBase), 64'd0);
        checkOutput("zero_no_val", 64'(valCount - valBase), 64'd0);
        checkOutput("zero_busy_low", 64'(busy), 64'd0);

        // Random backpressure: same stream as rdy=1, data held while stalled
        $display("[TB] random backpressure");
        hsBase = hsCount; doneBase = doneCount; stallBase = stallCount;
        randRdy = 1'b1;
        applyStimulus(64'd4, 4'd0, 1'b1, sc, dAtS);
        waitDone("bp", doneBase);
        randRdy = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("bp_beats", 64'(hsCount - hsBase), 64'd40);
        checkOutput("bp_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("bp_done_pulses", 64'(doneCount - doneBase), 64'd1);
        checkOutput("bp_saw_stall", 64'(stallCount > stallBase), 64'd1);

        // Address wrap at 2^ADDR_BITS
        $display("[TB] address wrap");
        hsBase = hsCount; doneBase = doneCount; rdBase = rdCount;
        applyStimulus(64'd1, 4'd14, 1'b1, sc, dAtS);
        waitDone("wrap", doneBase);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("wrap_reads", 64'(rdCount - rdBase), 64'd10);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("wrap_addr%0d", i),
                        64'((rdLog.size() > rdBase + i) ? int'(rdLog[rdBase + i]) : -1), 64'(wrapExp[i]));
        end
        checkOutput("wrap_queue_empty", 64'(expQ.size()), 64'd0);

        // Reset while packet 1 beat 2 is on the bus, then a clean restart
        $display("[TB] reset mid-packet");
        hsBase = hsCount;
        applyStimulus(64'd2, 4'd0, 1'b1, sc, dAtS);
        n = 0;
        while ((hsCount - hsBase < 8) && (n < TIMEOUT)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("rst_reached_beat", 64'(hsCount - hsBase), 64'd8);
        rstN = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        valBase = valCount;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("rst_no_stale_val", 64'(valCount - valBase), 64'd0);
        hsBase = hsCount; doneBase = doneCount;
        applyStimulus(64'd1, 4'd3, 1'b1, sc, dAtS);
        waitDone("restart", doneBase);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("restart_beats", 64'(hsCount - hsBase), 64'd10);
        checkOutput("restart_queue_empty", 64'(expQ.size()), 64'd0);

        // Start while busy is ignored
        $display("[TB] start while busy");
        hsBase = hsCount; doneBase = doneCount;
        applyStimulus(64'd2, 4'd0, 1'b1, sc, dAtS);
        repeat (4) @(posedge clk);
        #1;
        start    = 1'b1;
        numIn    = 64'd5;
        baseAddr = 4'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone("busy", doneBase);
        repeat (20) @(negedge clk);
        #1;
        checkOutput("busy_beats", 64'(hsCount - hsBase), 64'd20);
        checkOutput("busy_queue_empty", 64'(expQ.size()), 64'd0);
        checkOutput("busy_done_pulses", 64'(doneCount - doneBase), 64'd1);
        checkOutput("busy_idle_after", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multiexp_fp2_feeder.md
# multiexp_fp2_feeder

Transmit-side source for the G2 multiexp input stream. Reads G2 affine points and scalars from a point/scalar RAM and emits them as packets on an `if_axi_stream` source. The top-level multiexp sink consumes that stream. The full set of `i_num_in` points is replayed once per key bit (`NUM_PASSES` passes) so the sink's per-pass point/key counters close exactly. The block sits between the host-loaded RAM and the multiexp top, and absorbs RAM read latency with a credit-limited skid FIFO.

## Interface
Parameters:
- `DAT_BITS`, 381: beat width (one `FE_TYPE` word).
- `BEATS_PER_PNT`, 5: beats per packet (x.c0, x.c1, y.c0, y.c1, scalar).
- `NUM_PASSES`, `DAT_BITS`: replays of the point set; must equal the sink's key-bit count.
- `ADDR_BITS`, 20: RAM word-address width.
- `RD_LAT`, 2: fixed RAM read latency in cycles, ≥1.
- `FIFO_DEPTH`, 8: skid FIFO entries; must be ≥ `RD_LAT`+2 and a power of 2.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset. One clock; reset is synchronous and active-low.
- `i_start`, in, 1: start pulse, sampled in IDLE only.
- `i_num_in`, in, 64: number of points. Latched on start.
- `i_base_addr`, in, `ADDR_BITS`: RAM word address of point 0. Latched on start.
- `o_busy`, out, 1: high from the start-accept cycle to the cycle after the last eop handshake.
- `o_done`, out, 1: one-cycle pulse after the last eop handshake.
- `o_rd_en`, out, 1: RAM read strobe.
- `o_rd_addr`, out, `ADDR_BITS`: RAM read address.
- `i_rd_dat`, in, `DAT_BITS`: RAM data, valid `RD_LAT` cycles after `o_rd_en`.
- `o_pnt_scl_if`, `if_axi_stream.source`, `DAT_BITS`: output stream.

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE → RUN** on `i_start`. Latch `num_in` and `base`; clear `beat`, `pnt` and `pass`.
- **IDLE, `i_start` with `i_num_in`==0**: no reads and no output. Pulse `o_done` the next cycle and stay in IDLE.
- **RUN, read issue rules:**
  - Issue one read per cycle when credit allows: (FIFO occupancy + reads in flight) < `FIFO_DEPTH`.
  - Address = `base` + `pnt`*`BEATS_PER_PNT` + `beat`, truncated to `ADDR_BITS` (wraps mod 2^`ADDR_BITS`).
  - `beat` wraps at `BEATS_PER_PNT`-1 and then increments `pnt`.
  - `pnt` wraps at `num_in`-1 and then increments `pass`.
- **RUN → DRAIN** when the last read of pass `NUM_PASSES`-1 is issued.
- **DRAIN → IDLE** on the eop handshake of the final packet. `o_done` pulses the following cycle.
- **Read-return tracking:** a shift register of depth `RD_LAT` tracks valid returns. Each return is written into the FIFO together with its sop/eop flags.
  - sop = (`beat`==0).
  - eop = (`beat`==`BEATS_PER_PNT`-1).
- **Output fields:**
  - `dat` = FIFO head.
  - `val` = FIFO not empty.
  - `sop`/`eop` = stored flags.
  - `err`=0, `mod`=0, `ctl`=0. The sink overwrites the core-select bits of ctl itself.
- `i_start` is ignored while busy.
- The FIFO can never overflow by construction of the credit rule. An overflow is an assertion failure.
- **Mid-operation reset:** all state clears, in-flight read returns are dropped, and no partial packet continues after reset release.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_rd_en`=0, `o_rd_addr`=0, `val`=0, `sop`=0, `eop`=0, `dat`=0, FIFO empty.
- First read is issued in the cycle after start is accepted.
- First `val` appears `RD_LAT`+1 cycles after the first `o_rd_en`, because the FIFO is registered.
- With `rdy` held high, throughput is 1 beat/cycle. Total beats = `num_in`*`BEATS_PER_PNT`*`NUM_PASSES`, with no bubbles after fill.
- **Handshake:** a transfer occurs when `val`&&`rdy`. Once `val` is asserted, it and `dat` stay stable until the transfer completes.
- **Backpressure:** `rdy` low stops new reads within 1 cycle of credits running out. Returns still in flight land in FIFO headroom.
- **FIFO read/write collision:** simultaneous write and read on a full FIFO is legal, and occupancy stays unchanged.

## Configuration
- **`MULTIEXP_FEEDER_STATS_EN` defined:** adds output `o_stall_cnt` [31:0].
  - Counts cycles with `val`&&!`rdy` during a run.
  - Cleared on start accept and on reset.
  - Saturates at 2^32-1.
- **Macro undefined:** the port and counter are absent, and stream behaviour is identical.

## Test plan
- **Basic order:** `NUM_PASSES`=2, `num_in`=3, `rdy`=1, RAM word = address. Expect 30 beats with data 0..14 twice, sop on beats 0,5,10,…, eop on 4,9,14,…, and one `o_done` pulse.
- **Zero points:** start with `num_in`=0. Expect `o_rd_en` never high, `val` never high, and `o_done` high exactly one cycle later.
- **Random backpressure:** `rdy` randomly 30% low, `num_in`=4, `RD_LAT`=3. Expect a data sequence identical to the `rdy`=1 run, no FIFO overflow, and `dat` stable while stalled.
- **Address wrap:** `ADDR_BITS`=4, `base`=14, `num_in`=1. Expect read addresses 14, 15, 0, 1, 2.
- **Reset mid-packet:** assert `i_rst_n`=0 on beat 2 of packet 1. Expect all outputs at reset values the next cycle. A new start then yields a clean packet beginning with sop on data from `base`.
- **Start while busy:** pulse `i_start` during RUN with a different `num_in`. Expect it ignored and the beat count to match the original `num_in`.
